// File: rtl/omap_biu.sv
// Output map BIU: drains 64-bit output buffer words to external memory as
// pairs of 32-bit write beats (upper half first) through the arbiter.
module omap_biu (
   input  logic        clk,
   input  logic        rst,
   input  logic        omap_start,
   input  logic [31:0] omap_base_addr,
   input  logic [15:0] omap_words,
   output logic        omap_done,
   output logic        omap_ren,
   output logic [31:0] omap_raddr,
   input  logic [63:0] omap_rdata,
   output logic        omap_biu2arb_req,
   output logic [31:0] omap_biu2arb_addr,
   output logic [31:0] omap_biu2arb_wdata,
   output logic        omap_biu2arb_vld,
   input  logic        omap_biu2arb_rdy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      LOAD    = 3'd2,
      SEND_HI = 3'd3,
      SEND_LO = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] words_r;
   logic [15:0] word_idx;
   logic [63:0] hold;
   logic [63:0] pre;
   logic        pre_vld;
   logic        rd_pend;
   logic        accept;
   logic        more;
   logic [63:0] nxt_word;

   assign accept   = omap_biu2arb_vld & omap_biu2arb_rdy;
   assign more     = (word_idx + 16'd1) != words_r;
   // The prefetched word arrives on the first SEND_LO cycle; if the beat is
   // accepted right then, pre has not captured it yet, so bypass from the bus.
   assign nxt_word = pre_vld ? pre : omap_rdata;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      omap_ren   = 1'b0;
      omap_raddr = 32'd0;
      case (state)
         IDLE: begin
            if (omap_start) state_nxt = (omap_words == 16'd0) ? DONE : FETCH;
         end
         FETCH: begin
            omap_ren  = 1'b1;
            state_nxt = LOAD;
         end
         LOAD: state_nxt = SEND_HI;
         SEND_HI: begin
            if (accept) begin
               state_nxt = SEND_LO;
               if (more) begin
                  omap_ren   = 1'b1;
                  omap_raddr = {16'd0, word_idx + 16'd1};
               end
            end
         end
         SEND_LO: begin
            if (accept) state_nxt = more ? SEND_HI : DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         omap_done          <= 1'b0;
         omap_biu2arb_req   <= 1'b0;
         omap_biu2arb_addr  <= 32'd0;
         omap_biu2arb_wdata <= 32'd0;
         omap_biu2arb_vld   <= 1'b0;
         words_r            <= 16'd0;
         word_idx           <= 16'd0;
         hold               <= 64'd0;
         pre                <= 64'd0;
         pre_vld            <= 1'b0;
         rd_pend            <= 1'b0;
      end else begin
         omap_done <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (omap_start) begin
                  words_r           <= omap_words;
                  word_idx          <= 16'd0;
                  omap_biu2arb_addr <= omap_base_addr;
                  omap_biu2arb_req  <= (omap_words != 16'd0);
                  pre_vld           <= 1'b0;
                  rd_pend           <= 1'b0;
               end
            end
            LOAD: begin
               hold               <= omap_rdata;
               omap_biu2arb_wdata <= omap_rdata[63:32];
               omap_biu2arb_vld   <= 1'b1;
            end
            SEND_HI: begin
               rd_pend <= accept & more;
               if (accept) begin
                  omap_biu2arb_addr  <= omap_biu2arb_addr + 32'd4;
                  omap_biu2arb_wdata <= hold[31:0];
               end
            end
            SEND_LO: begin
               if (rd_pend) begin
                  pre     <= omap_rdata;
                  pre_vld <= 1'b1;
                  rd_pend <= 1'b0;
               end
               if (accept) begin
                  omap_biu2arb_addr <= omap_biu2arb_addr + 32'd4;
                  if (more) begin
                     hold               <= nxt_word;
                     omap_biu2arb_wdata <= nxt_word[63:32];
                     pre_vld            <= 1'b0;
                     word_idx           <= word_idx + 16'd1;
                  end else begin
                     omap_biu2arb_vld <= 1'b0;
                     omap_biu2arb_req <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
